// File: rtl/core_pkg.sv
// Shared definitions for the 16-bit 5-stage core: the 4-bit opcode map,
// the pipeline controller state encoding and the source-operand use decode.
package core_pkg;

   localparam logic [3:0] OP_NOP    = 4'b0000;
   localparam logic [3:0] OP_ADD    = 4'b0001;
   localparam logic [3:0] OP_SUB    = 4'b0010;
   localparam logic [3:0] OP_ADDI   = 4'b0011;
   localparam logic [3:0] OP_SHLLI  = 4'b0100;
   localparam logic [3:0] OP_SHRLI  = 4'b0101;
   localparam logic [3:0] OP_LOAD   = 4'b0110;
   localparam logic [3:0] OP_LOADI  = 4'b0111;
   localparam logic [3:0] OP_STORE  = 4'b1000;
   localparam logic [3:0] OP_CMP    = 4'b1001;
   localparam logic [3:0] OP_JUMP   = 4'b1010;
   localparam logic [3:0] OP_JUMPL  = 4'b1011;
   localparam logic [3:0] OP_JUMPG  = 4'b1100;
   localparam logic [3:0] OP_JUMPE  = 4'b1101;
   localparam logic [3:0] OP_JUMPNE = 4'b1110;
   localparam logic [3:0] OP_MOV    = 4'b1111;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_STALL = 2'd2
   } state_t;

   // Which source registers an opcode reads: bit0 = src1, bit1 = src2.
   function automatic logic [1:0] src_use(input logic [3:0] op);
      logic [1:0] use_bits;
      use_bits = 2'b00;
      case (op)
         OP_ADD, OP_SUB, OP_CMP, OP_STORE:                 use_bits = 2'b11;
         OP_ADDI, OP_SHLLI, OP_SHRLI, OP_LOAD, OP_MOV:     use_bits = 2'b01;
         default:                                          use_bits = 2'b00;
      endcase
      return use_bits;
   endfunction

endpackage

// File: rtl/pipeline_controller_if.sv
// Handshake bundle between the EX/ID stages and the pipeline controller.
//  ex_*        : instruction currently in Execute (valid, opcode, dest, target, new flags)
//  id_*        : instruction currently in Decode (valid, opcode, source indices)
//  zf/gf/lf    : architectural flag register
//  redirect, pc_target, stall_*, flush_* : front-end control
// master = pipeline side (drives stage info), slave = controller.
interface pipeline_controller_if;
   logic        ex_valid;
   logic [3:0]  ex_opcode;
   logic [4:0]  ex_dest_idx;
   logic [15:0] ex_target;
   logic        ex_zf;
   logic        ex_gf;
   logic        ex_lf;
   logic        id_valid;
   logic [3:0]  id_opcode;
   logic [4:0]  id_src1_idx;
   logic [4:0]  id_src2_idx;
   logic        zf;
   logic        gf;
   logic        lf;
   logic        redirect;
   logic [15:0] pc_target;
   logic        stall_pc;
   logic        stall_if_id;
   logic        flush_if_id;
   logic        flush_id_ex;

   modport master (
      output ex_valid, ex_opcode, ex_dest_idx, ex_target, ex_zf, ex_gf, ex_lf,
      output id_valid, id_opcode, id_src1_idx, id_src2_idx,
      input  zf, gf, lf, redirect, pc_target, stall_pc, stall_if_id,
      input  flush_if_id, flush_id_ex
   );

   modport slave (
      input  ex_valid, ex_opcode, ex_dest_idx, ex_target, ex_zf, ex_gf, ex_lf,
      input  id_valid, id_opcode, id_src1_idx, id_src2_idx,
      output zf, gf, lf, redirect, pc_target, stall_pc, stall_if_id,
      output flush_if_id, flush_id_ex
   );
endinterface

// File: rtl/hazard_detect.sv
// Load-use hazard detection between EX and ID (purely combinational).
//  ex_valid, ex_opcode, ex_dest_idx : producer in Execute
//  id_valid, id_opcode, id_src1_idx, id_src2_idx : consumer in Decode
//  load_use : EX holds a LOAD whose destination is read by the ID instruction
module hazard_detect
   import core_pkg::*;
(
   input  logic       ex_valid,
   input  logic [3:0] ex_opcode,
   input  logic [4:0] ex_dest_idx,
   input  logic       id_valid,
   input  logic [3:0] id_opcode,
   input  logic [4:0] id_src1_idx,
   input  logic [4:0] id_src2_idx,
   output logic       load_use
);

   logic [1:0] reads;
   logic       src_match;

   always_comb begin
      reads     = src_use(id_opcode);
      src_match = (reads[0] && (id_src1_idx == ex_dest_idx)) ||
                  (reads[1] && (id_src2_idx == ex_dest_idx));
      load_use  = ex_valid && (ex_opcode == OP_LOAD) && id_valid && src_match;
   end

endmodule

// File: rtl/pipeline_controller.sv
// Sequencing controller around the Execute stage: flag register, jump
// resolution with PC redirect and front-end flush, load-use stall.
//  clk, rst_n : core clock, asynchronous active-low reset
//  bus        : pipeline_controller_if.slave (EX/ID info in, control out)
//
// state | meaning
// ------+-----------------------------------------------------------------
// RUN   | normal flow; jumps resolve and load-use is checked
// FLUSH | trailing cycles of a taken jump; flush_if_id held, hazards ignored
// STALL | extra load-use bubbles; stall_pc/stall_if_id/flush_id_ex held
module pipeline_controller
   import core_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int LOAD_STALL   = 1,
   parameter int CNT_W        = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   pipeline_controller_if.slave  bus
);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             zf_q, gf_q, lf_q;
   logic             jump_cond;
   logic             jump_taken;
   logic             load_use;
   logic             stall_hit;

   hazard_detect u_hazard (
      .ex_valid    (bus.ex_valid),
      .ex_opcode   (bus.ex_opcode),
      .ex_dest_idx (bus.ex_dest_idx),
      .id_valid    (bus.id_valid),
      .id_opcode   (bus.id_opcode),
      .id_src1_idx (bus.id_src1_idx),
      .id_src2_idx (bus.id_src2_idx),
      .load_use    (load_use)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zf_q <= 1'b0;
         gf_q <= 1'b0;
         lf_q <= 1'b0;
      end else if (bus.ex_valid && (bus.ex_opcode == OP_CMP)) begin
         zf_q <= bus.ex_zf;
         gf_q <= bus.ex_gf;
         lf_q <= bus.ex_lf;
      end
   end

   // Conditions use the registered flags, never this cycle's ex_* flags.
   always_comb begin
      jump_cond = 1'b0;
      if (bus.ex_valid) begin
         case (bus.ex_opcode)
            OP_JUMP:   jump_cond = 1'b1;
            OP_JUMPL:  jump_cond = lf_q;
            OP_JUMPG:  jump_cond = gf_q;
            OP_JUMPE:  jump_cond = zf_q;
            OP_JUMPNE: jump_cond = !zf_q;
            default:   jump_cond = 1'b0;
         endcase
      end
   end

   // Jump has priority over a (theoretically impossible) coincident hazard.
   assign jump_taken = (state == ST_RUN) && jump_cond;
   assign stall_hit  = (state == ST_RUN) && !jump_cond && load_use;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_RUN;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         ST_RUN: begin
            if (jump_taken) begin
               if (FLUSH_CYCLES > 1) begin
                  state_nxt = ST_FLUSH;
                  cnt_nxt   = CNT_W'(FLUSH_CYCLES - 1);
               end
            end else if (stall_hit) begin
               if (LOAD_STALL > 1) begin
                  state_nxt = ST_STALL;
                  cnt_nxt   = CNT_W'(LOAD_STALL - 1);
               end
            end
         end
         ST_FLUSH, ST_STALL: begin
            // The cycle in which cnt reaches zero is the last one held.
            if (cnt <= CNT_W'(1)) begin
               state_nxt = ST_RUN;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         default: begin
            state_nxt = ST_RUN;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Outputs are forced low while reset is held so nothing leaks from the
   // combinational EX/ID decode during reset.
   always_comb begin
      bus.redirect    = 1'b0;
      bus.pc_target   = 16'h0000;
      bus.stall_pc    = 1'b0;
      bus.stall_if_id = 1'b0;
      bus.flush_if_id = 1'b0;
      bus.flush_id_ex = 1'b0;
      if (rst_n) begin
         case (state)
            ST_RUN: begin
               if (jump_taken) begin
                  bus.redirect    = 1'b1;
                  bus.pc_target   = bus.ex_target;
                  bus.flush_if_id = 1'b1;
                  bus.flush_id_ex = 1'b1;
               end else if (stall_hit) begin
                  bus.stall_pc    = 1'b1;
                  bus.stall_if_id = 1'b1;
                  bus.flush_id_ex = 1'b1;
               end
            end
            ST_FLUSH: bus.flush_if_id = 1'b1;
            ST_STALL: begin
               bus.stall_pc    = 1'b1;
               bus.stall_if_id = 1'b1;
               bus.flush_id_ex = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.zf = zf_q;
   assign bus.gf = gf_q;
   assign bus.lf = lf_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller: default instance (FLUSH_CYCLES=2,
// LOAD_STALL=1) plus a FLUSH_CYCLES=3 instance for the mid-flush reset case.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_pipeline_controller;
   import core_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   logic rst3_n;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   pipeline_controller_if bus();
   pipeline_controller_if bus3();

   pipeline_controller dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   pipeline_controller #(.FLUSH_CYCLES(3), .LOAD_STALL(1), .CNT_W(3)) dut3 (
      .clk   (clk),
      .rst_n (rst3_n),
      .bus   (bus3.slave)
   );

   // {redirect, stall_pc, stall_if_id, flush_if_id, flush_id_ex}
   logic [4:0] ctl, ctl3;
   logic [2:0] flg, flg3;
   assign ctl  = {bus.redirect, bus.stall_pc, bus.stall_if_id, bus.flush_if_id, bus.flush_id_ex};
   assign ctl3 = {bus3.redirect, bus3.stall_pc, bus3.stall_if_id, bus3.flush_if_id, bus3.flush_id_ex};
   assign flg  = {bus.zf, bus.gf, bus.lf};
   assign flg3 = {bus3.zf, bus3.gf, bus3.lf};

   task automatic drive_ex(input logic v, input logic [3:0] op, input logic [4:0] dest,
                           input logic [15:0] tgt, input logic z, input logic g, input logic l);
      bus.ex_valid    = v;
      bus.ex_opcode   = op;
      bus.ex_dest_idx = dest;
      bus.ex_target   = tgt;
      bus.ex_zf       = z;
      bus.ex_gf       = g;
      bus.ex_lf       = l;
   endtask

   task automatic drive_id(input logic v, input logic [3:0] op, input logic [4:0] s1, input logic [4:0] s2);
      bus.id_valid    = v;
      bus.id_opcode   = op;
      bus.id_src1_idx = s1;
      bus.id_src2_idx = s2;
   endtask

   task automatic drive_ex3(input logic v, input logic [3:0] op, input logic [4:0] dest,
                            input logic [15:0] tgt, input logic z, input logic g, input logic l);
      bus3.ex_valid    = v;
      bus3.ex_opcode   = op;
      bus3.ex_dest_idx = dest;
      bus3.ex_target   = tgt;
      bus3.ex_zf       = z;
      bus3.ex_gf       = g;
      bus3.ex_lf       = l;
   endtask

   task automatic drive_id3(input logic v, input logic [3:0] op, input logic [4:0] s1, input logic [4:0] s2);
      bus3.id_valid    = v;
      bus3.id_opcode   = op;
      bus3.id_src1_idx = s1;
      bus3.id_src2_idx = s2;
   endtask

   task automatic idle();
      drive_ex(1'b0, OP_NOP, 5'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
      drive_id(1'b0, OP_NOP, 5'd0, 5'd0);
   endtask

   task automatic idle3();
      drive_ex3(1'b0, OP_NOP, 5'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
      drive_id3(1'b0, OP_NOP, 5'd0, 5'd0);
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      rst3_n = 1'b0;
      // Hazard-looking inputs and a CMP on the other instance while in reset.
      drive_ex(1'b1, OP_LOAD, 5'd3, 16'hBEEF, 1'b1, 1'b1, 1'b1);
      drive_id(1'b1, OP_ADD, 5'd3, 5'd3);
      drive_ex3(1'b1, OP_CMP, 5'd0, 16'h0000, 1'b1, 1'b1, 1'b1);
      drive_id3(1'b0, OP_NOP, 5'd0, 5'd0);
      repeat (2) @(negedge clk);
      #1;
      total++; if (ctl !== 5'b00000) begin bad++; $display("FAIL reset_ctl got=%b exp=%b", ctl, 5'b00000); end
      total++; if (flg !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=%b", flg, 3'b000); end
      total++; if (bus.pc_target !== 16'h0000) begin bad++; $display("FAIL reset_pc_target got=%h exp=%h", bus.pc_target, 16'h0000); end
      total++; if (flg3 !== 3'b000) begin bad++; $display("FAIL reset_flags3 got=%b exp=%b", flg3, 3'b000); end
      @(negedge clk);
      idle();
      idle3();
      rst_n  = 1'b1;
      rst3_n = 1'b1;
      #1;
      total++; if (ctl !== 5'b00000) begin bad++; $display("FAIL reset_release_ctl got=%b exp=%b", ctl, 5'b00000); end
   endtask

   task automatic test_cmp_jumpg();
      @(negedge clk);
      drive_ex(1'b1, OP_CMP, 5'd0, 16'h0000, 1'b0, 1'b1, 1'b0);   // 10 vs 3
      #1;
      total++; if (ctl !== 5'b00000) begin bad++; $display("FAIL cmp_ctl got=%b exp=%b", ctl, 5'b00000); end
      total++; if (flg !== 3'b000) begin bad++; $display("FAIL cmp_flags_before_edge got=%b exp=%b", flg, 3'b000); end
      @(negedge clk);
      drive_ex(1'b1, OP_JUMPG, 5'd0, 16'h0040, 1'b0, 1'b0, 1'b0);
      #1;
      total++; if (flg !== 3'b010) begin bad++; $display("FAIL jumpg_flags got=%b exp=%b", flg, 3'b010); end
      total++; if (ctl !== 5'b10011) begin bad++; $display("FAIL jumpg_taken_ctl got=%b exp=%b", ctl, 5'b10011); end
      total++; if (bus.pc_target !== 16'h0040) begin bad++; $display("FAIL jumpg_pc_target got=%h exp=%h", bus.pc_target, 16'h0040); end
      @(negedge clk);
      // Second flush cycle; a matching load-use pair must be ignored here.
      drive_ex(1'b1, OP_LOAD, 5'd2, 16'h0000, 1'b0, 1'b0, 1'b0);
      drive_id(1'b1, OP_ADD, 5'd2, 5'd2);
      #1;
      total++; if (ctl !== 5'b00010) begin bad++; $display("FAIL jumpg_flush2_ctl got=%b exp=%b", ctl, 5'b00010); end
      @(negedge clk);
      idle();
      #1;
      total++; if (ctl !== 5'b00000) begin bad++; $display("FAIL jumpg_after_flush_ctl got=%b exp=%b", ctl, 5'b00000); end
   endtask

   task automatic test_jump_eq();
      @(negedge clk);
      drive_ex(1'b1, OP_CMP, 5'd0, 16'h0000, 1'b1, 1'b0, 1'b0);   // 5 vs 5
      #1;
      total++; if (ctl !== 5'b00000) begin bad++; $display("FAIL cmp_eq_ctl got=%b exp=%b", ctl, 5'b00000); end
      @(negedge clk);
      drive_ex(1'b1, OP_JUMPNE, 5'd0, 16'h0800, 1'b0, 1'b0, 1'b0);
      #1;
      total++; if (flg !== 3'b100) begin bad++; $display("FAIL cmp_eq_flags got=%b exp=%b", flg, 3'b100); end
      total++; if (ctl !== 5'b00000) begin bad++; $display("FAIL jumpne_not_taken_ctl got=%b exp=%b", ctl, 5'b00000); end
      @(negedge clk);
      idle();
      #1;
      total++; if (ctl !== 5'b00000) begin bad++; $display("FAIL jumpne_no_flush_ctl got=%b exp=%b", ctl, 5'b00000); end
      @(negedge clk);
      drive_ex(1'b1, OP_JUMPE, 5'd0, 16'h1234, 1'b0, 1'b0, 1'b0);
      #1;
      total++; if (ctl !== 5'b10011) begin bad++; $display("FAIL jumpe_taken_ctl got=%b exp=%b", ctl, 5'b10011); end
      total++; if (bus.pc_target !== 16'h1234) begin bad++; $display("FAIL jumpe_pc_target got=%h exp=%h", bus.pc_target, 16'h1234); end
      @(negedge clk);
      idle();
      #1;
      total++; if (ctl !== 5'b00010) begin bad++; $display("FAIL jumpe_flush2_ctl got=%b exp=%b", ctl, 5'b00010); end
      @(negedge clk);
      #1;
      total++; if (ctl !== 5'b00000) begin bad++; $display("FAIL jumpe_done_ctl got=%b exp=%b", ctl, 5'b00000); end
   endtask

   task automatic test_load_use();
      @(negedge clk);
      drive_ex(1'b1, OP_LOAD, 5'd2, 16'h0000, 1'b0, 1'b0, 1'b0);
      drive_id(1'b1, OP_ADD, 5'd7, 5'd2);
      #1;
      total++; if (ctl !== 5'b01101) begin bad++; $display("FAIL load_add_src2_ctl got=%b exp=%b", ctl, 5'b01101); end
      @(negedge clk);
      drive_ex(1'b0, OP_NOP, 5'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
      #1;
      total++; if (ctl !== 5'b00000) begin bad++; $display("FAIL load_single_bubble_ctl got=%b exp=%b", ctl, 5'b00000); end
      @(negedge clk);
      drive_ex(1'b1, OP_LOAD, 5'd2, 16'h0000, 1'b0, 1'b0, 1'b0);
      drive_id(1'b1, OP_LOADI, 5'd2, 5'd2);
      #1;
      total++; if (ctl !== 5'b00000) begin bad++; $display("FAIL load_loadi_ctl got=%b exp=%b", ctl, 5'b00000); end
      @(negedge clk);
      drive_id(1'b1, OP_ADDI, 5'd9, 5'd2);
      #1;
      total++; if (ctl !== 5'b00000) begin bad++; $display("FAIL load_addi_src2_only_ctl got=%b exp=%b", ctl, 5'b00000); end
      @(negedge clk);
      drive_id(1'b1, OP_STORE, 5'd2, 5'd0);
      #1;
      total++; if (ctl !== 5'b01101) begin bad++; $display("FAIL load_store_src1_ctl got=%b exp=%b", ctl, 5'b01101); end
      @(negedge clk);
      drive_id(1'b1, OP_MOV, 5'd2, 5'd11);
      #1;
      total++; if (ctl !== 5'b01101) begin bad++; $display("FAIL load_mov_src1_ctl got=%b exp=%b", ctl, 5'b01101); end
   endtask

   task automatic test_no_hazard();
      @(negedge clk);
      drive_ex(1'b1, OP_LOAD, 5'd4, 16'h0000, 1'b0, 1'b0, 1'b0);
      drive_id(1'b1, OP_JUMP, 5'd4, 5'd4);
      #1;
      total++; if (ctl !== 5'b00000) begin bad++; $display("FAIL load_jump_in_id_ctl got=%b exp=%b", ctl, 5'b00000); end
      @(negedge clk);
      drive_ex(1'b0, OP_LOAD, 5'd4, 16'h0000, 1'b0, 1'b0, 1'b0);
      drive_id(1'b1, OP_ADD, 5'd4, 5'd4);
      #1;
      total++; if (ctl !== 5'b00000) begin bad++; $display("FAIL load_ex_invalid_ctl got=%b exp=%b", ctl, 5'b00000); end
      @(negedge clk);
      drive_ex(1'b1, OP_LOAD, 5'd4, 16'h0000, 1'b0, 1'b0, 1'b0);
      drive_id(1'b0, OP_ADD, 5'd4, 5'd4);
      #1;
      total++; if (ctl !== 5'b00000) begin bad++; $display("FAIL load_id_invalid_ctl got=%b exp=%b", ctl, 5'b00000); end
      @(negedge clk);
      idle();
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      drive_ex(1'b1, OP_CMP, 5'd0, 16'h0000, 1'b0, 1'b0, 1'b1);   // 1 vs 2
      @(negedge clk);
      drive_ex(1'b1, OP_CMP, 5'd0, 16'h0000, 1'b0, 1'b1, 1'b0);   // 2 vs 1
      #1;
      total++; if (flg !== 3'b001) begin bad++; $display("FAIL b2b_first_cmp_flags got=%b exp=%b", flg, 3'b001); end
      @(negedge clk);
      drive_ex(1'b1, OP_JUMPL, 5'd0, 16'h0F00, 1'b0, 1'b0, 1'b0);
      #1;
      total++; if (flg !== 3'b010) begin bad++; $display("FAIL b2b_second_cmp_flags got=%b exp=%b", flg, 3'b010); end
      total++; if (ctl !== 5'b00000) begin bad++; $display("FAIL b2b_jumpl_not_taken_ctl got=%b exp=%b", ctl, 5'b00000); end
      @(negedge clk);
      idle();
   endtask

   task automatic test_flush3_reset();
      @(negedge clk);
      drive_ex3(1'b1, OP_CMP, 5'd0, 16'h0000, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      drive_ex3(1'b1, OP_JUMP, 5'd0, 16'h0100, 1'b0, 1'b0, 1'b0);
      #1;
      total++; if (flg3 !== 3'b100) begin bad++; $display("FAIL f3_flags got=%b exp=%b", flg3, 3'b100); end
      total++; if (ctl3 !== 5'b10011) begin bad++; $display("FAIL f3_taken_ctl got=%b exp=%b", ctl3, 5'b10011); end
      total++; if (bus3.pc_target !== 16'h0100) begin bad++; $display("FAIL f3_pc_target got=%h exp=%h", bus3.pc_target, 16'h0100); end
      @(negedge clk);
      idle3();
      #1;
      total++; if (ctl3 !== 5'b00010) begin bad++; $display("FAIL f3_flush2_ctl got=%b exp=%b", ctl3, 5'b00010); end
      @(negedge clk);
      #1;
      total++; if (ctl3 !== 5'b00010) begin bad++; $display("FAIL f3_flush3_ctl got=%b exp=%b", ctl3, 5'b00010); end
      @(negedge clk);
      #1;
      total++; if (ctl3 !== 5'b00000) begin bad++; $display("FAIL f3_done_ctl got=%b exp=%b", ctl3, 5'b00000); end
      // Second taken jump, reset during its second flush cycle.
      @(negedge clk);
      drive_ex3(1'b1, OP_JUMP, 5'd0, 16'h0200, 1'b0, 1'b0, 1'b0);
      #1;
      total++; if (ctl3 !== 5'b10011) begin bad++; $display("FAIL f3_retake_ctl got=%b exp=%b", ctl3, 5'b10011); end
      @(negedge clk);
      idle3();
      #1;
      total++; if (ctl3 !== 5'b00010) begin bad++; $display("FAIL f3_pre_reset_ctl got=%b exp=%b", ctl3, 5'b00010); end
      rst3_n = 1'b0;
      #1;
      total++; if (ctl3 !== 5'b00000) begin bad++; $display("FAIL f3_reset_ctl got=%b exp=%b", ctl3, 5'b00000); end
      total++; if (flg3 !== 3'b000) begin bad++; $display("FAIL f3_reset_flags got=%b exp=%b", flg3, 3'b000); end
      @(negedge clk);
      rst3_n = 1'b1;
      #1;
      total++; if (ctl3 !== 5'b00000) begin bad++; $display("FAIL f3_release_ctl got=%b exp=%b", ctl3, 5'b00000); end
      @(negedge clk);
      drive_ex3(1'b1, OP_LOAD, 5'd6, 16'h0000, 1'b0, 1'b0, 1'b0);
      drive_id3(1'b1, OP_SUB, 5'd6, 5'd1);
      #1;
      total++; if (ctl3 !== 5'b01101) begin bad++; $display("FAIL f3_run_after_reset_ctl got=%b exp=%b", ctl3, 5'b01101); end
      @(negedge clk);
      idle3();
   endtask

   initial begin
      idle();
      idle3();
      test_reset();
      test_cmp_jumpg();
      test_jump_eq();
      test_load_use();
      test_no_hazard();
      test_back_to_back();
      test_flush3_reset();
      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
